// File: rtl/icmp_reply_buf_pkg.sv
// ---------------------------------------------------------------------------
// icmp_reply_buf_pkg
//   Shared constants for the ICMP reply buffer: default widths, bit positions
//   of the 11-bit ICMP receive bus and the TX state encoding.
// ---------------------------------------------------------------------------
package icmp_reply_buf_pkg;

   localparam int AW_DEF     = 7;
   localparam int DROP_W_DEF = 8;

   // icmp_bus = {reply_ok, reply_strobe, reply_write, data[7:0]}
   localparam int BUS_OK  = 10;
   localparam int BUS_STB = 9;
   localparam int BUS_WR  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/icmp_reply_buf_dpram.sv
// ---------------------------------------------------------------------------
// icmp_reply_dpram
//   Simple dual-port RAM, 2*(2**AW) x 8, addressed {bank, ptr}.
//   Ports:
//     clk, rst_n        clock / async active-low reset (read register only)
//     i_we/i_waddr/i_wdata   write port
//     i_re/i_raddr      read port; o_rdata registered, updates only on i_re
// ---------------------------------------------------------------------------
module icmp_reply_dpram #(
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW:0]   i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic          i_re,
   input  logic [AW:0]   i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [0:(2**(AW+1))-1];
   logic [7:0] r_rdata;

   // Storage array carries no reset.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read data register is reset so the downstream tx_data starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= 8'h00;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/icmp_reply_buf.sv
// ---------------------------------------------------------------------------
// icmp_reply_buf
//   Captures ICMP echo payload bytes into ping-pong banks, commits a bank on a
//   good end-of-frame strobe, and streams committed replies to the TX arbiter
//   with a req/grant handshake.
//   Ports:
//     clk, rst_n        clock / async active-low reset
//     icmp_bus[10:0]    {reply_ok, reply_strobe, reply_write, data}
//     tx_req/tx_grant   request to / level grant from the TX arbiter
//     tx_len            octet count of the offered reply (valid with tx_req)
//     tx_data/tx_valid/tx_last   reply octet stream, no backpressure
//     busy              both banks hold untransmitted replies
//     drop_cnt          saturating count of overflow / no-space drops
// ---------------------------------------------------------------------------
module icmp_reply_buf
   import icmp_reply_buf_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DROP_W = DROP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [10:0]       icmp_bus,
   output logic              tx_req,
   input  logic              tx_grant,
   output logic [AW:0]       tx_len,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              tx_last,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   // ---------------- capture side ----------------
   logic [AW:0]       r_wr_ptr;
   logic              r_wr_bank;
   logic              r_ovf;
   logic              r_nospace;
   logic [1:0]        r_full;
   logic [1:0][AW:0]  r_len;
   logic [DROP_W-1:0] r_drop_cnt;

   logic              w_wr, w_stb, w_ok;
   logic              w_we, w_ovf_hit, w_nosp_hit;
   logic [AW:0]       w_ptr_nxt;
   logic              w_ovf_nxt, w_nosp_nxt;
   logic              w_commit, w_drop, w_done;

   // ---------------- TX side ----------------
   tx_state_e   r_state;
   logic        r_rd_bank;
   logic [AW:0] r_rd_ptr;
   logic [AW:0] r_rd_addr;
   logic        r_rd_en;
   logic        r_rd_last;
   logic        r_tx_req;
   logic [AW:0] r_tx_len;
   logic        r_tx_valid;
   logic        r_tx_last;
   logic        w_rd_final;
   logic [7:0]  w_rdata;

   assign w_wr  = icmp_bus[BUS_WR];
   assign w_stb = icmp_bus[BUS_STB];
   assign w_ok  = icmp_bus[BUS_OK];

   // A write to a full bank is refused before the overflow check applies.
   assign w_nosp_hit = w_wr &  r_full[r_wr_bank];
   assign w_ovf_hit  = w_wr & ~r_full[r_wr_bank] & (r_wr_ptr == DEPTH);
   assign w_we       = w_wr & ~r_full[r_wr_bank] & (r_wr_ptr != DEPTH);

   // "Next" views let a write in the strobe cycle count toward the commit.
   assign w_ptr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_we};
   assign w_ovf_nxt  = r_ovf | w_ovf_hit;
   assign w_nosp_nxt = r_nospace | w_nosp_hit;

   assign w_commit = w_stb & w_ok & ~w_ovf_nxt & ~w_nosp_nxt & (w_ptr_nxt != '0);
   assign w_drop   = w_stb & (w_ovf_nxt | w_nosp_nxt);

   // Bank release: DONE acts the cycle after tx_last is presented.
   assign w_done = (r_state == ST_DONE) & r_tx_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_wr_bank  <= 1'b0;
         r_ovf      <= 1'b0;
         r_nospace  <= 1'b0;
         r_full     <= 2'b00;
         r_len      <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_stb) begin
            r_wr_ptr  <= '0;
            r_ovf     <= 1'b0;
            r_nospace <= 1'b0;
         end else begin
            r_wr_ptr  <= w_ptr_nxt;
            r_ovf     <= w_ovf_nxt;
            r_nospace <= w_nosp_nxt;
         end
         // Commit and release always touch different banks: the bank being
         // transmitted is full, so it can never be the write target.
         if (w_commit) begin
            r_len[r_wr_bank]  <= w_ptr_nxt;
            r_full[r_wr_bank] <= 1'b1;
            r_wr_bank         <= ~r_wr_bank;
         end
         if (w_done) r_full[r_rd_bank] <= 1'b0;
         if (w_drop && (r_drop_cnt != {DROP_W{1'b1}}))
            r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign w_rd_final = (r_rd_ptr == r_tx_len - 1'b1);

   // TX FSM. Read address is registered (read issued), the RAM output
   // register follows one cycle later together with tx_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_rd_bank  <= 1'b0;
         r_rd_ptr   <= '0;
         r_rd_addr  <= '0;
         r_rd_en    <= 1'b0;
         r_rd_last  <= 1'b0;
         r_tx_req   <= 1'b0;
         r_tx_len   <= '0;
         r_tx_valid <= 1'b0;
         r_tx_last  <= 1'b0;
      end else begin
         r_tx_valid <= r_rd_en;
         r_tx_last  <= r_rd_en & r_rd_last;
         r_rd_en    <= 1'b0;
         r_rd_last  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  r_state  <= ST_REQ;
                  r_tx_req <= 1'b1;
                  r_tx_len <= r_len[r_rd_bank];
               end
            end
            ST_REQ: begin
               if (tx_grant) begin
                  r_state  <= ST_SEND;
                  r_tx_req <= 1'b0;
                  r_rd_ptr <= '0;
               end
            end
            ST_SEND: begin
               r_rd_en   <= 1'b1;
               r_rd_addr <= {r_rd_bank, r_rd_ptr[AW-1:0]};
               r_rd_last <= w_rd_final;
               r_rd_ptr  <= r_rd_ptr + 1'b1;
               if (w_rd_final) r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (r_tx_last) begin
                  r_rd_bank <= ~r_rd_bank;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   icmp_reply_dpram #(.AW(AW)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we),
      .i_waddr ({r_wr_bank, r_wr_ptr[AW-1:0]}),
      .i_wdata (icmp_bus[7:0]),
      .i_re    (r_rd_en),
      .i_raddr (r_rd_addr),
      .o_rdata (w_rdata)
   );

   assign tx_req   = r_tx_req;
   assign tx_len   = r_tx_len;
   assign tx_data  = w_rdata;
   assign tx_valid = r_tx_valid;
   assign tx_last  = r_tx_last;
   assign busy     = r_full[0] & r_full[1];
   assign drop_cnt = r_drop_cnt;

endmodule
